// File: rtl/npu_host_pkg.sv
// Shared types and constants for the NPU host sequencer: command opcodes,
// sequencer states, NPU region selects and control-word bit positions.
package npu_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RSP     = 3'd4
  } state_e;

  // NPU region selects
  localparam logic [2:0] SEL_IMG    = 3'd1;
  localparam logic [2:0] SEL_W      = 3'd2;
  localparam logic [2:0] SEL_FCN    = 3'd3;
  localparam logic [2:0] SEL_CTRL   = 3'd4;
  localparam logic [2:0] SEL_DONE   = 3'd5;
  localparam logic [2:0] SEL_RESULT = 3'd6;
  localparam logic [2:0] SEL_VALID  = 3'd7;

  // Bit positions inside the SEL_CTRL control word
  localparam int unsigned TRIG     = 0;
  localparam int unsigned NEXT     = 1;
  localparam int unsigned PE_CLR   = 2;
  localparam int unsigned IMG_CLR  = 3;
  localparam int unsigned W_CLR    = 4;
  localparam int unsigned PACK_CLR = 5;

  // Each region occupies a 4 KiB window; the region base is all the host needs.
  function automatic logic [15:0] npu_addr(input logic [2:0] sel);
    return {1'b0, sel, 12'h000};
  endfunction

endpackage

// File: rtl/npu_host_seq.sv
// Host-side command sequencer for the NPU register bus.
// Accepts WRITE / READ / POLL commands, drives a registered single-port bus
// (ena/wea/addra/dina, read data one cycle late on douta) and returns read
// results through a valid/ready response port.
// Build option: define NPU_HOST_POLL_EN to make POLL repeat reads until bit0
// of the read word is set or POLL_MAX reads have been made; without it a POLL
// is a single READ.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for a command, cmd_ready high
// ST_WR      | bus write cycle (ena=1, wea=1)
// ST_RD_REQ  | bus read request cycle (ena=1, wea=0)
// ST_RD_WAIT | NPU returns douta, word captured, poll decision made
// ST_RSP     | response held until rsp_ready
module npu_host_seq
  import npu_host_pkg::*;
#(
  parameter int unsigned POLL_MAX = 1024
) (
  input  logic        clk,
  input  logic        rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_sel,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic        ena,
  output logic        wea,
  output logic [15:0] addra,
  output logic [31:0] dina,
  input  logic [31:0] douta,
  output logic        busy
);

  if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_poll_max
    $error("npu_host_seq: POLL_MAX must be in 1..65535");
  end

  state_e      state_q, state_d;
  logic [2:0]  sel_q;
  logic        accept;
  logic        poll_again;
  logic        poll_expired;

  logic        cmd_ready_d;
  logic        ena_d, wea_d;
  logic [15:0] addra_d;
  logic [31:0] dina_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_data_d;
  logic        rsp_timeout_d;

  // cmd_ready is only ever high in ST_IDLE, so it alone qualifies the handshake
  assign accept = cmd_valid && cmd_ready;
  assign busy   = (state_q != ST_IDLE);

`ifdef NPU_HOST_POLL_EN
  localparam logic [16:0] POLL_LAST = 17'(POLL_MAX) - 17'd1;

  logic        is_poll_q;
  logic [15:0] poll_cnt_q;
  logic        poll_last;

  // poll_cnt_q counts reads already completed before the one now in RD_WAIT
  assign poll_last    = ({1'b0, poll_cnt_q} >= POLL_LAST);
  assign poll_again   = is_poll_q && !douta[0] && !poll_last;
  assign poll_expired = is_poll_q && !douta[0] && poll_last;

  // Poll bookkeeping: cleared on every accept, saturating read counter
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      is_poll_q  <= 1'b0;
      poll_cnt_q <= '0;
    end else if (accept) begin
      is_poll_q  <= (cmd_op_e'(cmd_op) == OP_POLL);
      poll_cnt_q <= '0;
    end else if (state_q == ST_RD_WAIT && poll_cnt_q != 16'hFFFF) begin
      poll_cnt_q <= poll_cnt_q + 16'd1;
    end
  end
`else
  assign poll_again   = 1'b0;
  assign poll_expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op_e'(cmd_op))
            OP_WRITE:         state_d = ST_WR;
            OP_READ, OP_POLL: state_d = ST_RD_REQ;
            default:          state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR:      state_d = ST_IDLE;
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = poll_again ? ST_RD_REQ : ST_RSP;
      ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output values for the next cycle, derived from the state being entered
  always_comb begin
    cmd_ready_d   = (state_d == ST_IDLE);
    ena_d         = (state_d == ST_WR) || (state_d == ST_RD_REQ);
    wea_d         = (state_d == ST_WR);
    addra_d       = ena_d ? npu_addr((state_q == ST_IDLE) ? cmd_sel : sel_q) : 16'h0000;
    dina_d        = wea_d ? cmd_data : 32'h0;
    rsp_valid_d   = (state_d == ST_RSP);
    rsp_data_d    = rsp_data;
    rsp_timeout_d = rsp_timeout;
    if (state_q == ST_RD_WAIT) begin
      rsp_data_d    = douta;
      rsp_timeout_d = poll_expired;
    end
  end

  // Registered outputs and latched region select
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_ready   <= 1'b0;
      ena         <= 1'b0;
      wea         <= 1'b0;
      addra       <= '0;
      dina        <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      sel_q       <= '0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      ena         <= ena_d;
      wea         <= wea_d;
      addra       <= addra_d;
      dina        <= dina_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_timeout <= rsp_timeout_d;
      if (accept) sel_q <= cmd_sel;
    end
  end

endmodule

// File: tb/tb_npu_host_seq.sv
// Self-checking bench for npu_host_seq: directed cases plus randomized
// commands compared against a command-level reference model.
module tb_npu_host_seq;
  import npu_host_pkg::*;

  localparam int PMAX = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [2:0]  cmd_sel = 3'd0;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic        ena, wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta = 32'h0;
  logic        busy;

  npu_host_seq #(.POLL_MAX(PMAX)) dut (
    .clk(clk), .rst_ni(rst_ni),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // NPU bus model: read words come from plan[], indexed by read number
  // within the current command; douta is registered like the real NPU.
  logic [31:0] plan [16];
  int          rd_cnt = 0, wr_cnt = 0, rd_base = 0;
  int          addr_err = 0, idle_err = 0;
  logic [15:0] exp_addr = 16'h0;
  logic [31:0] last_wr_addr = 32'h0, last_wr_data = 32'h0;

  always @(posedge clk) begin
    if (ena && !wea) begin
      int idx;
      idx = rd_cnt - rd_base;
      if (idx > 15) idx = 15;
      douta <= plan[idx];
      if (addra !== exp_addr) addr_err++;
      rd_cnt++;
    end
    if (ena && wea) begin
      wr_cnt++;
      last_wr_addr = {16'h0, addra};
      last_wr_data = dina;
    end
    if (!ena && (wea || dina != 32'h0)) idle_err++;
  end

  // Reference: how many reads a command makes and what it answers with
  function automatic void model(input logic [1:0] op, output int n_rd,
                                output logic [31:0] data, output logic tmo);
    n_rd = 1; data = plan[0]; tmo = 1'b0;
`ifdef NPU_HOST_POLL_EN
    if (op == 2'd2) begin
      for (int i = 0; i < PMAX; i++) begin
        n_rd = i + 1;
        data = plan[(i > 15) ? 15 : i];
        if (data[0]) break;
        if (i == PMAX - 1) tmo = 1'b1;
      end
    end
`endif
  endfunction

  // Issue one command (starting and ending at a negedge) and check it
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] sel,
                         input logic [31:0] data, input int hold);
    int          n_rd, lat, rd0, wr0, ae0, k;
    logic [31:0] edata;
    logic        etmo;
    model(op, n_rd, edata, etmo);
    exp_addr = {1'b0, sel, 12'h000};
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("ready_before_cmd", cmd_ready, 1);
    rd_base = rd_cnt; rd0 = rd_cnt; wr0 = wr_cnt; ae0 = addr_err;
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; cmd_data = data;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_data = $urandom; cmd_sel = 3'($urandom);
    @(negedge clk);
    if (op == 2'd0) begin
      chk("wr_ena", ena, 1);
      chk("wr_wea", wea, 1);
      chk("wr_addra", addra, exp_addr);
      chk("wr_dina", dina, data);
      chk("wr_busy", busy, 1);
      chk("wr_ready_low", cmd_ready, 0);
      @(negedge clk);
      chk("wr_ready_back", cmd_ready, 1);
      chk("wr_ena_off", ena, 0);
      chk("wr_count", wr_cnt - wr0, 1);
      chk("wr_data_bus", last_wr_data, data);
      chk("wr_no_reads", rd_cnt - rd0, 0);
      chk("wr_no_rsp", rsp_valid, 0);
    end else if (op == 2'd3) begin
      chk("rsvd_ready", cmd_ready, 1);
      repeat (3) begin
        @(negedge clk);
        chk("rsvd_no_rsp", rsp_valid, 0);
      end
      chk("rsvd_no_bus", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
    end else begin
      lat = 1;
      while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
      chk("rd_latency", lat, 2 * n_rd + 1);
      chk("rd_reads", rd_cnt - rd0, n_rd);
      chk("rd_no_write", wr_cnt - wr0, 0);
      chk("rd_addr", addr_err - ae0, 0);
      chk("rsp_data", rsp_data, edata);
      chk("rsp_timeout", rsp_timeout, etmo);
      chk("rsp_ready_low", cmd_ready, 0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, edata);
        chk("hold_tmo", rsp_timeout, etmo);
        chk("hold_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_done", rsp_valid, 0);
      chk("ready_after_rsp", cmd_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          done_at, saw;
    logic [1:0]  op;
    for (int i = 0; i < 16; i++) plan[i] = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_bus", {ena, wea, addra != 16'h0, dina != 32'h0}, 4'h0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_data != 32'h0, busy}, 4'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // Directed: write, read, poll done on 4th read, poll timeout
    run_cmd(2'd0, SEL_IMG, 32'h0003_0201, 0);
    plan[0] = 32'h0000_00A5;
    run_cmd(2'd1, SEL_RESULT, 32'h0, 0);
    for (int i = 0; i < 16; i++) plan[i] = (i >= 3) ? 32'h1 : 32'h0;
    run_cmd(2'd2, SEL_DONE, 32'h0, 0);
    for (int i = 0; i < 16; i++) plan[i] = 32'h100 + 32'(i * 2);
    run_cmd(2'd2, SEL_DONE, 32'h0, 0);

    // Response back-pressure for 5 cycles
    plan[0] = 32'hCAFE_F00D;
    run_cmd(2'd1, SEL_VALID, 32'h0, 5);

    // Reserved op is swallowed
    run_cmd(2'd3, SEL_CTRL, 32'hFFFF_FFFF, 0);

    // Reset during RD_WAIT
    plan[0] = 32'h1234_5678;
    exp_addr = {1'b0, SEL_RESULT, 12'h000};
    rd_base = rd_cnt;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_sel = SEL_RESULT; rsp_ready = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b0;
    @(negedge clk);
    chk("midrst_bus", {ena, wea, addra != 16'h0, dina != 32'h0}, 4'h0);
    chk("midrst_rsp", {rsp_valid, rsp_timeout, busy, cmd_ready}, 4'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    saw = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) saw++; end
    chk("midrst_no_rsp", saw, 0);
    chk("midrst_ready", cmd_ready, 1);
    plan[0] = 32'h0BAD_BEEF;
    run_cmd(2'd1, SEL_RESULT, 32'h0, 0);

    // Randomized commands
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      done_at = $urandom_range(1, 11);
      for (int i = 0; i < 16; i++) begin
        w = $urandom;
        if (op == 2'd2) w[0] = (i + 1 >= done_at);
        plan[i] = w;
      end
      w = $urandom;
      run_cmd(op, 3'($urandom), w, $urandom_range(0, 3));
    end

    chk("idle_bus_clean", idle_err, 0);
    chk("addr_errors", addr_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
